sym_fir_pipe_filter: RTL and testbench

// Pipelined symmetric-coefficient FIR filter; selectable even/odd total tap count.
// Pre-adds mirrored taps and registers each arithmetic stage.

---
 rtl/sym_fir_pipe_filter_if.sv | 27 ++
 rtl/sym_fir_pipe_filter.sv | 186 ++++++++++++++++++
 tb/tb_sym_fir_pipe_filter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sym_fir_pipe_filter_if.sv
// Streaming port bundle for sym_fir_pipe_filter.
// Carries the input side (data_in/valid_in/ready_out) and the output side
// (data_out/valid_out/ready_in/overflow).
// The slave modport is the filter's view. The master modport is the view of
// the surrounding producer/consumer.
interface sym_fir_pipe_filter_if #(
  parameter int unsigned IW = 16,
  parameter int unsigned OW = 16
);
  logic signed [IW-1:0] data_in;
  logic                 valid_in;
  logic                 ready_out;
  logic signed [OW-1:0] data_out;
  logic                 valid_out;
  logic                 ready_in;
  logic                 overflow;

  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out, overflow
  );

  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out, overflow
  );
endinterface

// File: rtl/sym_fir_pipe_filter.sv
// Pipelined symmetric-coefficient FIR filter with round/saturate output stage.
// Mirrored taps are pre-added, then multiplied by the unique coefficients and
// reduced through a registered pairwise adder tree. A single enable
// (~valid_out | ready_in) advances every stage, so a stalled consumer freezes
// the whole pipe.
// Ports:
//   clk  - clock, all logic on posedge
//   srst - synchronous active-high reset, clears delay line and pipeline
//   bus  - slave side of sym_fir_pipe_filter_if. It carries:
//          data_in/valid_in/ready_out   (input stream)
//          data_out/valid_out/ready_in  (output stream)
//          overflow                     (output sample was clamped)
module sym_fir_pipe_filter #(
  parameter int unsigned INPUT_WORD_SIZE  = 16,
  parameter int unsigned COEFF_WORD_SIZE  = 16,
  parameter int unsigned N_COEFFS         = 5,
  parameter int unsigned ODD_TAPS         = 0,
  parameter int unsigned OUTPUT_WORD_SIZE = 16,
  parameter int unsigned ROUND_SHIFT      = 15,
  parameter logic [N_COEFFS-1:0][COEFF_WORD_SIZE-1:0] COEFFS = '0
) (
  input logic              clk,
  input logic              srst,
  sym_fir_pipe_filter_if.slave bus
);

  localparam int unsigned IW      = INPUT_WORD_SIZE;
  localparam int unsigned CW      = COEFF_WORD_SIZE;
  localparam int unsigned OW      = OUTPUT_WORD_SIZE;
  localparam int unsigned TAPS    = (ODD_TAPS != 0) ? 2 * N_COEFFS - 1 : 2 * N_COEFFS;
  localparam int unsigned HIST    = (TAPS > 1) ? TAPS - 1 : 1;
  localparam int unsigned LV      = (N_COEFFS > 1) ? $clog2(N_COEFFS) : 0;
  localparam int unsigned P_W     = IW + 1;
  localparam int unsigned M_W     = P_W + CW;
  localparam int unsigned ACC_W   = M_W + LV;
  localparam int unsigned S       = 2 + LV;
  localparam int unsigned R_W     = ACC_W + 1;
  localparam int unsigned E_W     = ((R_W > OW) ? R_W : OW) + 1;
  localparam int unsigned RND_POS = (ROUND_SHIFT > 0) ? ROUND_SHIFT - 1 : 0;
  localparam logic signed [R_W-1:0] RND =
    (ROUND_SHIFT > 0) ? R_W'(1) << RND_POS : R_W'(0);
  localparam logic signed [E_W-1:0] SAT_MAX = {{(E_W - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [E_W-1:0] SAT_MIN = {{(E_W - OW + 1){1'b1}}, {(OW - 1){1'b0}}};

  // Number of partial sums present at adder-tree level l (level 0 = products).
  function automatic int unsigned lvl_cnt(input int unsigned l);
    int unsigned d;
    d = 32'd1 << l;
    return (N_COEFFS + d - 1) / d;
  endfunction

  // Offset of tree level l (l >= 1) inside node_q.
  function automatic int unsigned lvl_off(input int unsigned l);
    int unsigned o;
    o = 0;
    for (int unsigned i = 1; i < l; i++) o += lvl_cnt(i);
    return o;
  endfunction

  // Offset of level l inside all_c, where the products occupy the first N slots.
  function automatic int unsigned aoff(input int unsigned l);
    return (l == 0) ? 0 : N_COEFFS + lvl_off(l);
  endfunction

  localparam int unsigned NODES  = lvl_off(LV + 1);
  localparam int unsigned NODE_N = (NODES > 0) ? NODES : 1;

  logic                    en_c;
  logic                    accept_c;
  logic signed [IW-1:0]    hist_q [HIST];
  logic signed [IW-1:0]    x_c    [TAPS];
  logic signed [P_W-1:0]   p_q    [N_COEFFS];
  logic signed [M_W-1:0]   m_q    [N_COEFFS];
  logic signed [ACC_W-1:0] node_q [NODE_N];
  logic signed [ACC_W-1:0] all_c  [N_COEFFS + NODE_N];
  logic [S-1:0]            vld_q;
  logic signed [ACC_W-1:0] acc_c;
  logic signed [R_W-1:0]   rnd_c;
  logic signed [E_W-1:0]   rext_c;
  logic signed [OW-1:0]    data_out_d, data_out_q;
  logic                    overflow_d, overflow_q;
  logic                    valid_out_q;

  // Pipe advances whenever the output slot is empty or being taken.
  assign en_c          = ~valid_out_q | bus.ready_in;
  assign accept_c      = bus.valid_in & en_c;
  assign bus.ready_out = en_c;
  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.overflow  = overflow_q;

  // Tap vector: x[0] is the sample being accepted, x[i] the i-th older one.
  always_comb begin
    x_c[0] = bus.data_in;
    for (int unsigned i = 1; i < TAPS; i++) x_c[i] = hist_q[i-1];
  end

  // Delay line shifts only on an accepted sample.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int unsigned i = 0; i < HIST; i++) hist_q[i] <= '0;
    end else if (accept_c) begin
      hist_q[0] <= bus.data_in;
      for (int unsigned i = 1; i < HIST; i++) hist_q[i] <= hist_q[i-1];
    end
  end

  // Pre-add and multiply stages.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int unsigned k = 0; k < N_COEFFS; k++) begin
        p_q[k] <= '0;
        m_q[k] <= '0;
      end
    end else if (en_c) begin
      for (int unsigned k = 0; k < N_COEFFS; k++) begin
        // The odd-length centre tap has no mirror partner and is not doubled.
        if ((ODD_TAPS != 0) && (k == N_COEFFS - 1))
          p_q[k] <= P_W'(x_c[k]);
        else
          p_q[k] <= P_W'(x_c[k]) + P_W'(x_c[TAPS-1-k]);
        m_q[k] <= M_W'(p_q[k]) * M_W'($signed(COEFFS[k]));
      end
    end
  end

  // Flat view of products followed by the tree nodes, for uniform indexing.
  always_comb begin
    for (int unsigned k = 0; k < N_COEFFS; k++) all_c[k] = ACC_W'(m_q[k]);
    for (int unsigned o = 0; o < NODE_N; o++) all_c[N_COEFFS + o] = node_q[o];
  end

  // Registered pairwise adder tree. An unpaired element passes through.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int unsigned o = 0; o < NODE_N; o++) node_q[o] <= '0;
    end else if (en_c) begin
      for (int unsigned l = 1; l <= LV; l++) begin
        for (int unsigned j = 0; j < lvl_cnt(l); j++) begin
          if (2 * j + 1 < lvl_cnt(l - 1))
            node_q[lvl_off(l) + j] <= all_c[aoff(l - 1) + 2 * j]
                                    + all_c[aoff(l - 1) + 2 * j + 1];
          else
            node_q[lvl_off(l) + j] <= all_c[aoff(l - 1) + 2 * j];
        end
      end
    end
  end

  assign acc_c = (LV == 0) ? all_c[0] : all_c[N_COEFFS + lvl_off(LV)];

  // Valid shadow pipe, one bit per arithmetic stage before the output.
  always_ff @(posedge clk) begin
    if (srst)      vld_q <= '0;
    else if (en_c) vld_q <= {vld_q[S-2:0], accept_c};
  end

  // Round half up, then clamp to the output range.
  always_comb begin
    rnd_c      = R_W'(acc_c) + RND;
    rext_c     = E_W'(rnd_c >>> ROUND_SHIFT);
    data_out_d = OW'(rext_c);
    overflow_d = 1'b0;
    if (rext_c > SAT_MAX) begin
      data_out_d = OW'(SAT_MAX);
      overflow_d = vld_q[S-1];
    end else if (rext_c < SAT_MIN) begin
      data_out_d = OW'(SAT_MIN);
      overflow_d = vld_q[S-1];
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (srst) begin
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      valid_out_q <= 1'b0;
    end else if (en_c) begin
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      valid_out_q <= vld_q[S-1];
    end
  end

endmodule

// File: tb/tb_sym_fir_pipe_filter.sv
// Directed bench for sym_fir_pipe_filter: impulse responses (even/odd taps),
// saturation, rounding, backpressure against a reference convolution, and
// mid-stream reset.
`timescale 1ns/1ps
module tb_sym_fir_pipe_filter;

  logic clk = 1'b0;
  logic srst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sym_fir_pipe_filter_if #(.IW(16), .OW(40)) b1 ();
  sym_fir_pipe_filter_if #(.IW(16), .OW(40)) b2 ();
  sym_fir_pipe_filter_if #(.IW(16), .OW(16)) b3 ();
  sym_fir_pipe_filter_if #(.IW(16), .OW(16)) b4 ();

  sym_fir_pipe_filter #(
    .INPUT_WORD_SIZE(16), .COEFF_WORD_SIZE(16), .N_COEFFS(3), .ODD_TAPS(0),
    .OUTPUT_WORD_SIZE(40), .ROUND_SHIFT(0), .COEFFS({16'd3, 16'd2, 16'd1})
  ) u1 (.clk(clk), .srst(srst), .bus(b1));

  sym_fir_pipe_filter #(
    .INPUT_WORD_SIZE(16), .COEFF_WORD_SIZE(16), .N_COEFFS(3), .ODD_TAPS(1),
    .OUTPUT_WORD_SIZE(40), .ROUND_SHIFT(0), .COEFFS({16'd3, 16'd2, 16'd1})
  ) u2 (.clk(clk), .srst(srst), .bus(b2));

  sym_fir_pipe_filter #(
    .INPUT_WORD_SIZE(16), .COEFF_WORD_SIZE(16), .N_COEFFS(2), .ODD_TAPS(0),
    .OUTPUT_WORD_SIZE(16), .ROUND_SHIFT(0), .COEFFS({16'h7FFF, 16'h7FFF})
  ) u3 (.clk(clk), .srst(srst), .bus(b3));

  sym_fir_pipe_filter #(
    .INPUT_WORD_SIZE(16), .COEFF_WORD_SIZE(16), .N_COEFFS(1), .ODD_TAPS(1),
    .OUTPUT_WORD_SIZE(16), .ROUND_SHIFT(1), .COEFFS(16'd1)
  ) u4 (.clk(clk), .srst(srst), .bus(b4));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  longint q1[$], q2[$], q3[$], q4[$], xin[$];
  int     c1[$];
  bit     o2[$], o3[$];
  bit     bp_en = 1'b0;
  bit     stall_prev = 1'b0;
  longint data_prev = 0;

  // Output monitors and stall-stability checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (!srst) begin
      if (b1.valid_out && b1.ready_in) begin
        q1.push_back(longint'(b1.data_out));
        c1.push_back(cyc);
      end
      if (b1.valid_in && b1.ready_out) xin.push_back(longint'(b1.data_in));
      if (b2.valid_out) begin q2.push_back(longint'(b2.data_out)); o2.push_back(b2.overflow); end
      if (b3.valid_out) begin q3.push_back(longint'(b3.data_out)); o3.push_back(b3.overflow); end
      if (b4.valid_out) q4.push_back(longint'(b4.data_out));
      if (bp_en) begin
        if (stall_prev) begin
          check("bp_hold_data", longint'(b1.data_out), data_prev);
          check("bp_hold_valid", longint'(b1.valid_out), 1);
        end
        if (b1.valid_out && !b1.ready_in) check("bp_ready_out", longint'(b1.ready_out), 0);
      end
      stall_prev <= b1.valid_out && !b1.ready_in;
      data_prev  <= longint'(b1.data_out);
    end
  end

  function automatic int qsize(input int w);
    case (w)
      1:       return q1.size();
      2:       return q2.size();
      3:       return q3.size();
      default: return q4.size();
    endcase
  endfunction

  task automatic wait_q(input int which, input int n, input string tag);
    int t = 0;
    while (qsize(which) < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (qsize(which) < n) check(tag, qsize(which), n);
  endtask

  task automatic send1(input longint v);
    int t = 0;
    b1.data_in  = 16'(v);
    b1.valid_in = 1'b1;
    @(negedge clk);
    while (!b1.ready_out && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!b1.ready_out) check("send_timeout", longint'(b1.ready_out), 1);
    @(posedge clk);
    #1;
    b1.valid_in = 1'b0;
  endtask

  // Impulse through u1 (T=6, coeffs 1,2,3); checks latency and response.
  task automatic run_impulse1(input string tag);
    longint exp1[8] = '{1, 2, 3, 3, 2, 1, 0, 0};
    int     t0 = 0;
    q1.delete();
    c1.delete();
    for (int i = 0; i < 8; i++) begin
      b1.data_in  = (i == 0) ? 16'sd1 : 16'sd0;
      b1.valid_in = 1'b1;
      if (i == 0) begin
        @(negedge clk);
        t0 = cyc;
      end
      @(posedge clk);
      #1;
    end
    b1.valid_in = 1'b0;
    wait_q(1, 8, {tag, "_timeout"});
    if (c1.size() > 0) check({tag, "_latency"}, longint'(c1[0] - t0), 5);
    for (int i = 0; i < 8; i++)
      if (i < q1.size()) check($sformatf("%s_y%0d", tag, i), q1[i], exp1[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    longint exp2[8] = '{1, 2, 3, 2, 1, 0, 0, 0};
    longint exp4[4] = '{2, -1, 1, 0};
    longint in4[4]  = '{3, -3, 1, -1};
    longint h[6]    = '{1, 2, 3, 3, 2, 1};
    longint acc;
    logic signed [15:0] r;
    bit done;

    srst = 1'b1;
    b1.data_in = '0; b1.valid_in = 1'b0; b1.ready_in = 1'b1;
    b2.data_in = '0; b2.valid_in = 1'b0; b2.ready_in = 1'b1;
    b3.data_in = '0; b3.valid_in = 1'b0; b3.ready_in = 1'b1;
    b4.data_in = '0; b4.valid_in = 1'b0; b4.ready_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid_out1", longint'(b1.valid_out), 0);
    check("rst_data_out1", longint'(b1.data_out), 0);
    check("rst_overflow1", longint'(b1.overflow), 0);
    check("rst_ready_out1", longint'(b1.ready_out), 1);
    check("rst_valid_out3", longint'(b3.valid_out), 0);
    check("rst_data_out3", longint'(b3.data_out), 0);
    @(posedge clk);
    #1;
    srst = 1'b0;

    // Even taps impulse response.
    run_impulse1("even");

    // Odd taps impulse response, no overflow.
    for (int i = 0; i < 8; i++) begin
      b2.data_in  = (i == 0) ? 16'sd1 : 16'sd0;
      b2.valid_in = 1'b1;
      @(posedge clk);
      #1;
    end
    b2.valid_in = 1'b0;
    wait_q(2, 8, "odd_timeout");
    for (int i = 0; i < 8; i++)
      if (i < q2.size()) begin
        check($sformatf("odd_y%0d", i), q2[i], exp2[i]);
        check($sformatf("odd_ovf%0d", i), longint'(o2[i]), 0);
      end

    // Saturation both directions.
    for (int i = 0; i < 16; i++) begin
      b3.data_in  = (i < 8) ? 16'sh7FFF : 16'sh8000;
      b3.valid_in = 1'b1;
      @(posedge clk);
      #1;
    end
    b3.valid_in = 1'b0;
    wait_q(3, 16, "sat_timeout");
    for (int i = 0; i < 16; i++)
      if (i < q3.size() && (i < 8 || i > 10)) begin
        check($sformatf("sat_y%0d", i), q3[i], (i < 8) ? 32767 : -32768);
        check($sformatf("sat_ovf%0d", i), longint'(o3[i]), 1);
      end

    // Round half up with shift 1.
    for (int i = 0; i < 4; i++) begin
      b4.data_in  = 16'(in4[i]);
      b4.valid_in = 1'b1;
      @(posedge clk);
      #1;
    end
    b4.valid_in = 1'b0;
    wait_q(4, 4, "rnd_timeout");
    for (int i = 0; i < 4; i++)
      if (i < q4.size()) check($sformatf("rnd_y%0d", i), q4[i], exp4[i]);

    // Backpressure: random stream with bubbles vs reference convolution.
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
    q1.delete(); c1.delete(); xin.delete();
    done  = 1'b0;
    bp_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            b1.valid_in = 1'b0;
            @(posedge clk);
            #1;
          end
          r = 16'($urandom);
          send1(longint'(r));
        end
        done = 1'b1;
      end
      begin
        int bp_cyc = 0;
        while (!done) begin
          @(posedge clk);
          #1;
          bp_cyc++;
          b1.ready_in = (bp_cyc >= 60 && bp_cyc < 65) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
        b1.ready_in = 1'b1;
      end
    join
    wait_q(1, 200, "bp_timeout");
    bp_en = 1'b0;
    check("bp_accepted", longint'(xin.size()), 200);
    check("bp_count", longint'(q1.size()), 200);
    for (int n = 0; n < 200; n++) begin
      acc = 0;
      for (int i = 0; i < 6; i++)
        if (n - i >= 0 && n - i < xin.size()) acc += h[i] * xin[n-i];
      if (n < q1.size()) check($sformatf("bp_y%0d", n), q1[n], acc);
    end

    // Reset mid-stream while a sample is being offered.
    @(posedge clk);
    #1;
    for (int i = 1; i <= 3; i++) begin
      b1.data_in  = 16'(100 * i);
      b1.valid_in = 1'b1;
      @(posedge clk);
      #1;
    end
    b1.data_in = 16'sd500;
    srst       = 1'b1;
    @(posedge clk);
    #1;
    srst        = 1'b0;
    b1.valid_in = 1'b0;
    q1.delete();
    @(negedge clk);
    check("srst_valid_out", longint'(b1.valid_out), 0);
    check("srst_data_out", longint'(b1.data_out), 0);
    check("srst_overflow", longint'(b1.overflow), 0);
    repeat (8) @(negedge clk);
    check("srst_no_residue", longint'(q1.size()), 0);
    @(posedge clk);
    #1;
    run_impulse1("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
